// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle main control FSM (optional PERF_COUNTERS_EN adds InstrCount/CycleCount)
module multicycle_control_fsm #(
    parameter logic [2:0] OPCODE_HALT = 3'b111
`ifdef PERF_COUNTERS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [2:0] opcode,
    input  logic       InstrReady,
    input  logic       MemReady,
    output logic       RegDst,
    output logic       Branch,
    output logic       BranchNe,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       MemToReg,
    output logic       ALUSrc,
    output logic [1:0] ALUOp,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       Halted,
    output logic [2:0] State
`ifdef PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0] InstrCount,
    output logic [CNT_W-1:0] CycleCount
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [2:0] OP_R    = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_SLTI = 3'b010;
    localparam logic [2:0] OP_LW   = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_BEQ  = 3'b101;
    localparam logic [2:0] OP_BNE  = 3'b110;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] op_q;

    logic       is_r;
    logic       is_lw;
    logic       is_sw;
    logic       is_bne;
    logic       is_branch;
    logic       uses_imm;
    logic [1:0] alu_class;

    // State register; the opcode is latched only on the DECODE edge so later
    // states never depend on whatever the datapath presents afterwards.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_FETCH;
            op_q    <= 3'b000;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
            end
        end
    end

    // Instruction class decode from the latched opcode.
    always_comb begin
        is_r      = (op_q == OP_R);
        is_lw     = (op_q == OP_LW);
        is_sw     = (op_q == OP_SW);
        is_bne    = (op_q == OP_BNE);
        is_branch = (op_q == OP_BEQ) || (op_q == OP_BNE);
        uses_imm  = (op_q == OP_ADDI) || (op_q == OP_SLTI) || is_lw || is_sw;
        case (op_q)
            OP_R:          alu_class = 2'b10;
            OP_SLTI:       alu_class = 2'b11;
            OP_BEQ, OP_BNE: alu_class = 2'b01;
            default:       alu_class = 2'b00;
        endcase
    end

    // Next-state and control strobes; Reset forces every output low in the same cycle.
    always_comb begin
        state_d  = state_q;
        RegDst   = 1'b0;
        Branch   = 1'b0;
        BranchNe = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        MemToReg = 1'b0;
        ALUSrc   = 1'b0;
        ALUOp    = 2'b00;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        Halted   = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite = InstrReady;
                if (InstrReady) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = (opcode == OPCODE_HALT) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                ALUOp  = alu_class;
                ALUSrc = uses_imm;
                if (is_branch) begin
                    Branch   = 1'b1;
                    BranchNe = is_bne;
                    PCWrite  = 1'b1;
                    state_d  = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                ALUSrc   = 1'b1;
                ALUOp    = 2'b00;
                MemRead  = is_lw;
                MemWrite = is_sw;
                if (MemReady) begin
                    if (is_sw) begin
                        PCWrite = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                RegDst   = is_r;
                MemToReg = is_lw;
                if (!is_lw) begin
                    ALUSrc = uses_imm;
                    ALUOp  = alu_class;
                end
                state_d = S_FETCH;
            end
            S_HALT: begin
                Halted  = 1'b1;
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        if (Reset) begin
            RegDst   = 1'b0;
            Branch   = 1'b0;
            BranchNe = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            MemToReg = 1'b0;
            ALUSrc   = 1'b0;
            ALUOp    = 2'b00;
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            Halted   = 1'b0;
        end
    end

    assign State = state_q;

`ifdef PERF_COUNTERS_EN
    // Retired-instruction and active-cycle counters, wrapping naturally.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            InstrCount <= '0;
            CycleCount <= '0;
        end else begin
            if (PCWrite) begin
                InstrCount <= InstrCount + CNT_W'(1);
            end
            if (state_q != S_HALT) begin
                CycleCount <= CycleCount + CNT_W'(1);
            end
        end
    end
`endif

endmodule
